// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: one shift/add or shift/subtract step per cycle,
// with MTHI/MTLO completing as single-cycle writes.
module mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             req_ready,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               sx_q, sx_d;
  logic               dbz_flag_q, dbz_flag_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   x_abs, y_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Next-state, datapath step and output computation
  always_comb begin
    op_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
    op_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned
    x_abs     = (op_signed && req_x[WIDTH-1]) ? WIDTH'(-req_x) : req_x;
    y_abs     = (op_signed && req_y[WIDTH-1]) ? WIDTH'(-req_y) : req_y;

    mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, rem_sh} - {2'b00, opb_q};
    div_ok    = ~div_diff[WIDTH+1];
    rem_new   = div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    prod_fix  = neg_q ? (2*WIDTH)'(-acc_q) : acc_q;
    quot_fix  = neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix   = sx_q ? WIDTH'(-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    sx_d       = sx_q;
    dbz_flag_d = dbz_flag_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          unique case (req_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_d      = op_div ? {{WIDTH{1'b0}}, x_abs} : {{WIDTH{1'b0}}, y_abs};
              opb_d      = op_div ? y_abs : x_abs;
              is_div_d   = op_div;
              sx_d       = op_signed & req_x[WIDTH-1];
              neg_d      = op_signed & (req_x[WIDTH-1] ^ req_y[WIDTH-1]);
              dbz_flag_d = op_div && (req_y == '0);
              cnt_d      = CNT_W'(WIDTH - 1);
              state_d    = CALC;
            end
            OP_MTHI: hi_d = req_x;
            OP_MTLO: lo_d = req_x;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? {rem_new, acc_q[WIDTH-2:0], div_ok}
                           : {mul_sum, acc_q[WIDTH-1:1]};
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (is_div_q) begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
          dbz_d  = dbz_flag_q;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      sx_q       <= 1'b0;
      dbz_flag_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      sx_q       <= sx_d;
      dbz_flag_q <= dbz_flag_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
